// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and constants for the bit-serial subtractor
//
// Contents:
//   DEFAULT_WIDTH - default operand/result width
//   state_t       - controller state encoding (IDLE, RUN, DONE), 2 bits
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// rtl/serial_subtractor_fs_bit.sv - combinational 1-bit full-subtractor cell
//
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow in from the less significant bit
//   d    out difference bit (a - b - bin)
//   bout out borrow out to the next more significant bit
module fs_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when the minuend bit is 0 and the subtrahend bit is 1, or when
    // the bits are equal and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, diff = a - b, LSB first
//
// Ports:
//   clk        in  clock, rising edge
//   rst        in  synchronous active-high reset
//   start      in  request, sampled only in IDLE or DONE
//   a, b       in  [WIDTH] minuend / subtrahend, captured on an accepted start
//   busy       out high while the serial operation runs
//   done       out one-cycle pulse, diff/borrow_out valid
//   diff       out [WIDTH] (a - b) mod 2^WIDTH, held until the next result
//   borrow_out out 1 iff a < b (unsigned), held like diff
//   ovf        out signed overflow flag, only with SERIAL_SUBTRACTOR_OVF_EN defined
//
// Build option: SERIAL_SUBTRACTOR_OVF_EN adds the ovf output.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    count;
    logic             bw;
    logic             d;
    logic             bnext;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // Operand sign bits are kept because the shift registers lose them.
    logic             a_msb;
    logic             b_msb;
`endif

    fs_bit u_fs_bit (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (bw),
        .d    (d),
        .bout (bnext)
    );

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            count      <= '0;
            bw         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        bw    <= 1'b0;
                        count <= '0;
                        state <= RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    res   <= {d, res[WIDTH-1:1]};
                    bw    <= bnext;
                    count <= count + CW'(1);
                    // The edge that consumes the last bit also publishes the
                    // result, so diff never shows a partially shifted value.
                    if (count == LAST) begin
                        state      <= DONE;
                        diff       <= {d, res[WIDTH-1:1]};
                        borrow_out <= bnext;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf        <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic       ovf;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] last_diff = 8'h00;
    logic       last_bo   = 1'b0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs[9];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v, input int idx);
        int   cyc;
        int   nbusy;
        logic held_ok;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        a = v.a;
        b = v.b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        cyc = 1;
        nbusy = 0;
        held_ok = 1'b1;
        while (!done && cyc < 20) begin
            if (busy) nbusy++;
            if (diff !== last_diff || borrow_out !== last_bo) held_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, " done_cycle"}, cyc, 9);
        chk({tag, " busy_cycles"}, nbusy, 8);
        chk({tag, " held_during_run"}, held_ok, 1);
        chk({tag, " busy_at_done"}, busy, 0);
        chk({tag, " diff"}, diff, v.d);
        chk({tag, " borrow_out"}, borrow_out, v.bo);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk({tag, " ovf"}, ovf, v.ov);
`endif
        last_diff = v.d;
        last_bo   = v.bo;
        @(posedge clk);
        #1;
        chk({tag, " done_single"}, done, 0);
        chk({tag, " idle_after"}, busy, 0);
        chk({tag, " diff_hold"}, diff, v.d);
    endtask

    initial begin
        int ndone;
        logic exp_done;

        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[7] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[8] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset diff", diff, 8'h00);
        chk("reset borrow_out", borrow_out, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("reset ovf", ovf, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 9; i++) do_op(vecs[i], i);

        // start re-asserted with other operands while running is ignored
        @(negedge clk);
        a = 8'h5A;
        b = 8'h3C;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'hFF;
        b = 8'h01;
        repeat (6) @(posedge clk);
        #1;
        chk("ignore busy_c8", busy, 1);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("ignore done_c9", done, 1);
        chk("ignore diff", diff, 8'h1E);
        chk("ignore borrow_out", borrow_out, 0);
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("ignore extra_done", ndone, 0);
        last_diff = 8'h1E;
        last_bo   = 1'b0;

        // reset in cycle 4 of RUN aborts without a done pulse
        @(negedge clk);
        a = 8'h10;
        b = 8'h20;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort busy_c4", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort diff", diff, 8'h00);
        chk("abort borrow_out", borrow_out, 0);
        ndone = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort no_done", ndone, 0);
        last_diff = 8'h00;
        last_bo   = 1'b0;

        // start held high: back-to-back results with no idle cycle
        @(negedge clk);
        a = 8'h03;
        b = 8'h01;
        start = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            @(posedge clk);
            #1;
            exp_done = (c % 9 == 0);
            chk($sformatf("b2b busy_done c%0d", c), {busy, done}, {~exp_done, exp_done});
            if (exp_done) chk($sformatf("b2b diff c%0d", c), diff, 8'h02);
            if (c == 27) start = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("b2b idle busy", busy, 0);
        chk("b2b idle done", done, 0);
        chk("b2b diff_hold", diff, 8'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
